// File: rtl/cpu_types_pkg.sv
// Basic machine types shared across the pipeline.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pipeline_regs_pkg.sv
// Inter-stage latch layouts and the fetch-stage state encoding.
package pipeline_regs_pkg;

    import cpu_types_pkg::*;

    // Fetch/decode latch: instruction word plus the sequential return address.
    typedef struct packed {
        word_t instr;
        word_t pc_plus_4;
    } FD_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Sequential successor, modulo 2^32 so the top word wraps to zero.
    function automatic word_t next_seq_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between fetch (master) and I-cache (slave).
interface fetch_stage_if;

    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    modport master (
        input  ihit,
        input  imemload,
        output imemREN,
        output imemaddr
    );

    modport slave (
        output ihit,
        output imemload,
        input  imemREN,
        input  imemaddr
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, I-cache request and registered FD latch to decode.
// Latency: a word hit in cycle n is on fd_out/fd_valid in cycle n+1; one instr/cycle on back-to-back hits.
// Backpressure: stall freezes pc and the FD latch; a miss inserts bubbles; a redirect during a miss drains it first.
module fetch_stage
    import cpu_types_pkg::*;
    import pipeline_regs_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          redirect,
    input  word_t         redirect_pc,
    input  logic          halt,
    output FD_t           fd_out,
    output logic          fd_valid
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n;
    word_t        pending, pending_n;
    word_t        pc_inc;
    FD_t          fd_n;
    logic         fd_valid_n;

    assign pc_inc        = next_seq_pc(pc);
    assign imem.imemaddr = pc;
    assign imem.imemREN  = (state != HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            pc       <= PC_INIT;
            pending  <= '0;
            fd_out   <= '0;
            fd_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pending  <= pending_n;
            fd_out   <= fd_n;
            fd_valid <= fd_valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pending_n  = pending;
        fd_n       = fd_out;
        fd_valid_n = fd_valid;

        unique case (state)
            FETCH: begin
                if (halt) begin
                    state_n    = HALTED;
                    fd_n       = '0;
                    fd_valid_n = 1'b0;
                end else if (redirect) begin
                    fd_n       = '0;
                    fd_valid_n = 1'b0;
                    if (imem.ihit) begin
                        pc_n = redirect_pc;
                    end else begin
                        // Address must stay put until the cache answers; park the target.
                        pending_n = redirect_pc;
                        state_n   = DRAIN;
                    end
                end else if (stall) begin
                    // Hold everything; a word returned now is refetched after release.
                    pc_n = pc;
                end else if (imem.ihit) begin
                    fd_n.instr     = imem.imemload;
                    fd_n.pc_plus_4 = pc_inc;
                    fd_valid_n     = 1'b1;
                    pc_n           = pc_inc;
                end else begin
                    fd_n       = '0;
                    fd_valid_n = 1'b0;
                end
            end

            DRAIN: begin
                fd_n       = '0;
                fd_valid_n = 1'b0;
                if (halt) begin
                    state_n = HALTED;
                end else begin
                    if (redirect) begin
                        pending_n = redirect_pc;
                    end
                    if (imem.ihit) begin
                        // Newest target wins even when it arrives with the draining hit.
                        pc_n    = redirect ? redirect_pc : pending;
                        state_n = FETCH;
                    end
                end
            end

            HALTED: begin
                fd_n       = '0;
                fd_valid_n = 1'b0;
            end

            default: begin
                state_n    = FETCH;
                fd_n       = '0;
                fd_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hits, misses, stall, redirect/drain, halt, reset and PC wrap.
module tb_fetch_stage;

    import cpu_types_pkg::*;
    import pipeline_regs_pkg::*;

    logic  CLK;
    logic  RST;
    logic  stall, redirect, halt;
    word_t redirect_pc;
    FD_t   fd_out;
    logic  fd_valid;

    logic  stall_b, redirect_b, halt_b;
    word_t redirect_pc_b;
    FD_t   fd_out_b;
    logic  fd_valid_b;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage_if ifa ();
    fetch_stage_if ifb ();

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem        (ifa.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fd_out      (fd_out),
        .fd_valid    (fd_valid)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK         (CLK),
        .RST         (RST),
        .imem        (ifb.master),
        .stall       (stall_b),
        .redirect    (redirect_b),
        .redirect_pc (redirect_pc_b),
        .halt        (halt_b),
        .fd_out      (fd_out_b),
        .fd_valid    (fd_valid_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected FD latch contents as a flat 64-bit value.
    function automatic logic [63:0] fd(input word_t instr, input word_t pc4);
        return {instr, pc4};
    endfunction

    initial begin
        RST = 1'b1; stall = 0; redirect = 0; halt = 0; redirect_pc = '0;
        stall_b = 0; redirect_b = 0; halt_b = 0; redirect_pc_b = '0;
        ifa.ihit = 0; ifa.imemload = '0;
        ifb.ihit = 0; ifb.imemload = '0;
        step(); step();
        RST = 1'b0;

        // Reset state
        check("rst_addr",  ifa.imemaddr, 32'h0);
        check("rst_ren",   ifa.imemREN, 1'b1);
        check("rst_valid", fd_valid, 1'b0);
        check("rst_fd",    fd_out, 64'h0);

        // Back-to-back hits
        ifa.ihit = 1; ifa.imemload = 32'h1111_0000; step();
        check("hit0_fd", fd_out, fd(32'h1111_0000, 32'h4));
        check("hit0_v",  fd_valid, 1'b1);
        check("hit0_a",  ifa.imemaddr, 32'h4);
        ifa.imemload = 32'h2222_0000; step();
        check("hit1_fd", fd_out, fd(32'h2222_0000, 32'h8));
        check("hit1_a",  ifa.imemaddr, 32'h8);
        ifa.imemload = 32'h3333_0000; step();
        check("hit2_fd", fd_out, fd(32'h3333_0000, 32'hC));
        check("hit2_a",  ifa.imemaddr, 32'hC);
        ifa.imemload = 32'h4444_0000; step();
        check("hit3_a",  ifa.imemaddr, 32'h10);

        // Miss for three cycles at 0x10, then hit
        ifa.ihit = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("miss_a", ifa.imemaddr, 32'h10);
            check("miss_v", fd_valid, 1'b0);
        end
        ifa.ihit = 1; ifa.imemload = 32'h8C22_0000; step();
        check("mhit_fd", fd_out, fd(32'h8C22_0000, 32'h14));
        check("mhit_v",  fd_valid, 1'b1);

        // Advance to 0x20
        ifa.imemload = 32'hAAAA_0000;
        for (int i = 0; i < 3; i++) step();
        check("pre_stall_a",  ifa.imemaddr, 32'h20);
        check("pre_stall_fd", fd_out, fd(32'hAAAA_0000, 32'h20));

        // Stall two cycles with ihit
        stall = 1; ifa.imemload = 32'hDEAD_0020;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_a",  ifa.imemaddr, 32'h20);
            check("stall_fd", fd_out, fd(32'hAAAA_0000, 32'h20));
            check("stall_v",  fd_valid, 1'b1);
        end
        stall = 0; step();
        check("rel_fd", fd_out, fd(32'hDEAD_0020, 32'h24));
        check("rel_a",  ifa.imemaddr, 32'h24);
        ifa.imemload = 32'hBEEF_0024; step();
        check("rel2_fd", fd_out, fd(32'hBEEF_0024, 32'h28));

        // Advance 0x28 -> 0x40
        ifa.imemload = 32'h0000_0000;
        for (int i = 0; i < 6; i++) step();
        check("pre_drain_a", ifa.imemaddr, 32'h40);

        // Redirect during miss, then a second redirect, then the draining hit
        ifa.ihit = 0; redirect = 1; redirect_pc = 32'h100; step();
        check("drain0_a",   ifa.imemaddr, 32'h40);
        check("drain0_v",   fd_valid, 1'b0);
        check("drain0_ren", ifa.imemREN, 1'b1);
        redirect_pc = 32'h200; step();
        check("drain1_a", ifa.imemaddr, 32'h40);
        redirect = 0; ifa.ihit = 1; ifa.imemload = 32'h1234_5678; step();
        check("drain2_a", ifa.imemaddr, 32'h200);
        check("drain2_v", fd_valid, 1'b0);
        ifa.imemload = 32'h5555_0200; step();
        check("post_drain_fd", fd_out, fd(32'h5555_0200, 32'h204));
        check("post_drain_a",  ifa.imemaddr, 32'h204);

        // Redirect with hit: immediate retarget
        redirect = 1; redirect_pc = 32'h300; step();
        check("redir_hit_a", ifa.imemaddr, 32'h300);
        check("redir_hit_v", fd_valid, 1'b0);

        // Halt together with redirect
        halt = 1; redirect_pc = 32'h500; step();
        check("halt_ren", ifa.imemREN, 1'b0);
        check("halt_a",   ifa.imemaddr, 32'h300);
        check("halt_v",   fd_valid, 1'b0);
        halt = 0; redirect = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("halted_ren", ifa.imemREN, 1'b0);
            check("halted_a",   ifa.imemaddr, 32'h300);
            check("halted_v",   fd_valid, 1'b0);
        end
        RST = 1; step(); RST = 0;
        check("halt_rst_a",   ifa.imemaddr, 32'h0);
        check("halt_rst_ren", ifa.imemREN, 1'b1);

        // Reset mid-drain discards the pending target
        ifa.ihit = 0; redirect = 1; redirect_pc = 32'h80; step();
        redirect = 0;
        RST = 1; step(); RST = 0;
        ifa.ihit = 1; ifa.imemload = 32'h6666_0000; step();
        check("drain_rst_a",  ifa.imemaddr, 32'h4);
        check("drain_rst_fd", fd_out, fd(32'h6666_0000, 32'h4));

        // PC wrap on the second instance (was reset together with the first)
        check("wrap_init_a", ifb.imemaddr, 32'hFFFF_FFFC);
        ifb.ihit = 1; ifb.imemload = 32'h0BAD_F00D; step();
        check("wrap_fd", fd_out_b, fd(32'h0BAD_F00D, 32'h0));
        check("wrap_a",  ifb.imemaddr, 32'h0);
        check("wrap_v",  fd_valid_b, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
